// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_CLK_PER_BIT = 868;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for an asynchronous serial line, resets to idle-high.
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {meta, q} <= 2'b11;
    else {meta, q} <= {d, meta};
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with mid-bit sampling.
// Define UART_RX_FRAME_ERR_EN to check the stop bit and expose frame_error.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic [DATA_W-1:0] recv_data,
  output logic              recv_ok,
  output logic              rx_busy
`ifdef UART_RX_FRAME_ERR_EN
  , output logic            frame_error
`endif
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);
  logic rx_s, rx_prev, sample;
  uart_rx_state_t state;
  logic [CW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [DATA_W-1:0] shift;
  uart_sync u_sync (.clk(clk), .reset(reset), .d(rx_in), .q(rx_s));
  // The start bit is sampled at its midpoint; every later sample is a full bit apart.
  assign sample = baud == (state == START ? HALF_M1 : FULL_M1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rx_prev <= 1'b1;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      recv_data <= '0;
      recv_ok <= 1'b0;
      rx_busy <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_error <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_s;
      recv_ok <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_error <= 1'b0;
`endif
      baud <= sample || state == IDLE ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (rx_prev && !rx_s) begin
            state <= START;
            rx_busy <= 1'b1;
          end
        end
        START: if (sample) begin
          state <= rx_s ? IDLE : DATA;
          rx_busy <= !rx_s;
        end
        DATA: if (sample) begin
          shift[bit_cnt] <= rx_s;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: if (sample) begin
          state <= IDLE;
          rx_busy <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            recv_data <= shift;
            recv_ok <= 1'b1;
          end else frame_error <= 1'b1;
`else
          recv_data <= shift;
          recv_ok <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random frames checked against a byte-queue reference.
module tb_uart_receiver;
  localparam int CPB = 16;
  logic clk = 1'b0, reset = 1'b1, rx_in = 1'b1;
  logic [7:0] recv_data;
  logic recv_ok, rx_busy, fe;
  int total = 0, passed = 0;
  logic [7:0] exp_q[$], got_q[$];
  int fe_cnt = 0, exp_fe = 0, bad_change = 0, ok_long = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_ok = 1'b0;
  uart_receiver #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in),
    .recv_data(recv_data), .recv_ok(recv_ok), .rx_busy(rx_busy)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_error(fe)
`endif
  );
`ifndef UART_RX_FRAME_ERR_EN
  assign fe = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (recv_ok) got_q.push_back(recv_data);
    if (fe) fe_cnt++;
    if (recv_ok && prev_ok) ok_long++;
    if (!reset && !recv_ok && recv_data !== last_data) bad_change++;
    prev_ok = recv_ok;
    last_data = recv_data;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Model: a frame yields its byte unless the stop bit is checked and low.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
`ifdef UART_RX_FRAME_ERR_EN
    if (stop_bit) exp_q.push_back(b);
    else exp_fe++;
`else
    exp_q.push_back(b);
`endif
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask
  task automatic expect_frames(input string tag);
    int n;
    repeat (6) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_data"}, got_q[i], exp_q[i]);
    check({tag, "_ferr"}, fe_cnt, exp_fe);
    check({tag, "_busy"}, rx_busy, 1'b0);
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    logic saw;
    logic [7:0] b;
    logic s;
    repeat (2) @(negedge clk);
    check("rst_data", recv_data, 8'h00);
    check("rst_ok", recv_ok, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_fe", fe, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h55, 1'b1);
    expect_frames("f55");
    check("f55_recv_data", recv_data, 8'h55);
    saw = 1'b0;
    rx_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw |= rx_busy;
    end
    rx_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw |= rx_busy;
      if (saw && !rx_busy) break;
    end
    check("glitch_seen", saw, 1'b1);
    check("glitch_busy_drop", rx_busy, 1'b0);
    expect_frames("glitch");
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    expect_frames("b2b");
    send_frame(8'hA3, 1'b0);
    repeat (CPB) @(negedge clk);
    expect_frames("badstop");
`ifdef UART_RX_FRAME_ERR_EN
    check("badstop_hold", recv_data, 8'hFF);
`else
    check("badstop_data", recv_data, 8'hA3);
`endif
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = i[1:0] < 2 ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("mid_busy_before_rst", rx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", rx_busy, 1'b0);
    check("async_rst_data", recv_data, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("abort_no_strobe", got_q.size(), 0);
    send_frame(8'hC3, 1'b1);
    expect_frames("after_rst");
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s);
      repeat (s ? $urandom_range(0, 20) : CPB + $urandom_range(0, 20)) @(negedge clk);
    end
    expect_frames("random");
    check("ok_single_cycle", ok_long, 0);
    check("data_only_with_ok", bad_change, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal values >= 4.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset; driven by the buffer controller's recv_reset.
REQ-004 SHALL have port rx_in  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port recv_data  output  8  last received byte; feeds the buffer controller's recv_data.
REQ-006 SHALL have port recv_ok  output  1  single-cycle strobe, recv_data valid in the same cycle; feeds recv_ok.
REQ-007 SHALL have port rx_busy  output  1  high from start-bit detection until the frame ends or is aborted.
REQ-008 SHALL have port frame_error  output  1  single-cycle strobe on a bad stop bit; present only with UART_RX_FRAME_ERR_EN.

Function
REQ-009 SHALL pass rx_in through a 2-flop synchronizer; sampling logic SHALL see only the synchronized value (rx_s).
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 IDLE: SHALL move to START when rx_s goes from 1 (previous cycle) to 0 (current cycle); a line held low SHALL NOT retrigger.
REQ-012 START: SHALL sample rx_s after CLK_PER_BIT/2 cycles (integer divide); 0 -> DATA, 1 -> IDLE (glitch reject, no strobe).
REQ-013 DATA: SHALL sample rx_s every CLK_PER_BIT cycles from the start-bit midpoint, 8 samples; bit i goes to shift-register bit i (LSB first).
REQ-014 STOP: SHALL sample rx_s CLK_PER_BIT cycles after the 8th data sample, then return to IDLE on the next edge, enabling back-to-back frames.
REQ-015 On a valid stop sample (1), SHALL update recv_data and pulse recv_ok high for exactly 1 cycle, on the cycle after the stop sample.
REQ-016 recv_data SHALL hold its value between strobes; it SHALL change only together with recv_ok.
REQ-017 Baud counter width SHALL be $clog2(CLK_PER_BIT); it wraps to 0 on each sample; bit counter 3 bits, 0..7.
REQ-018 rx_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-019 No backpressure: recv_ok SHALL fire regardless of downstream state; overflow handling belongs downstream.

Reset
REQ-020 On reset assertion, asynchronously: FSM=IDLE, counters=0, recv_data=0x00, recv_ok=0, rx_busy=0, frame_error=0, synchronizer flops=1.
REQ-021 Reset mid-frame SHALL discard the partial byte with no strobe; after release, SHALL wait for a fresh 1->0 edge.

Configuration
REQ-022 With UART_RX_FRAME_ERR_EN defined: a stop sample of 0 SHALL pulse frame_error for 1 cycle (same timing as REQ-015), SHALL NOT pulse recv_ok, and SHALL leave recv_data unchanged.
REQ-023 Without UART_RX_FRAME_ERR_EN: the frame_error port SHALL be absent, the stop bit SHALL NOT be checked, and every frame reaching STOP SHALL produce recv_ok.

Structure
REQ-024 Package uart_pkg SHALL hold the FSM state enum typedef (uart_rx_state_t), the 8-bit data width constant and the default CLK_PER_BIT constant.
REQ-025 The synchronizer SHALL be a sub-module uart_sync (2 flops, reset value 1), reusable by the transmitter side.

Verification (CLK_PER_BIT=16 in all benches)
REQ-026 Send frame 0x55 with a good stop bit -> exactly one recv_ok; recv_data=0x55; rx_busy low afterwards.
REQ-027 Drive a 3-cycle low glitch on idle line -> no recv_ok, rx_busy returns to 0 after at most 8+2 cycles.
REQ-028 Send back-to-back frames 0x00 then 0xFF, no idle gap -> two recv_ok pulses, values 0x00 then 0xFF.
REQ-029 Send 0xA3 with stop bit 0 -> with macro: frame_error pulse, no recv_ok, recv_data keeps its prior value; without macro: recv_ok, recv_data=0xA3.
REQ-030 Assert reset during data bit 4 of 0x3C, then send 0xC3 -> no strobe for 0x3C; exactly one recv_ok with recv_data=0xC3.
